// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle signed/unsigned multiply and restoring divide with hi/lo result
module muldiv_unit #(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quot_q;
    logic [WIDTH-1:0]   dvs_q;
    logic               neg_quot;
    logic               neg_rem;

    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] ma;
    logic [2*WIDTH-1:0] mb;
    logic [2*WIDTH-1:0] prod_full;
    logic               can_accept;

    // Operands sign-extended to the product width so one unsigned multiply serves both forms.
    assign sgn        = ~op[0];
    assign a_neg      = sgn & a[WIDTH-1];
    assign b_neg      = sgn & b[WIDTH-1];
    assign a_mag      = a_neg ? -a : a;
    assign b_mag      = b_neg ? -b : b;
    assign ma         = {{WIDTH{a_neg}}, a};
    assign mb         = {{WIDTH{b_neg}}, b};
    assign prod_full  = ma * mb;
    assign can_accept = start && (state == IDLE || state == DONE);

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             ge;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] quot_n;

    // One restoring step: the dividend shifts out of quot_q as quotient bits shift in.
    assign shifted = {rem_q, quot_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign ge      = ~diff[WIDTH];
    assign rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quot_n  = {quot_q[WIDTH-2:0], ge};

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvs_q    <= '0;
            neg_quot <= 1'b0;
            neg_rem  <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            div_zero <= 1'b0;
        end else if (cancel) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (can_accept) begin
                        if (op[1]) begin
                            if (b == '0) begin
                                state    <= DONE;
                                hi       <= a;
                                lo       <= '1;
                                div_zero <= 1'b1;
                            end else begin
                                state    <= DIV;
                                cnt      <= CW'(WIDTH);
                                rem_q    <= '0;
                                quot_q   <= a_mag;
                                dvs_q    <= b_mag;
                                neg_quot <= a_neg ^ b_neg;
                                neg_rem  <= a_neg;
                            end
                        end else begin
                            prod_q <= prod_full;
                            if (MUL_LAT == 1) begin
                                state    <= DONE;
                                hi       <= prod_full[2*WIDTH-1:WIDTH];
                                lo       <= prod_full[WIDTH-1:0];
                                div_zero <= 1'b0;
                            end else begin
                                state <= MUL;
                                cnt   <= CW'(MUL_LAT - 1);
                            end
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                MUL: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        hi       <= prod_q[2*WIDTH-1:WIDTH];
                        lo       <= prod_q[WIDTH-1:0];
                        div_zero <= 1'b0;
                    end
                end
                DIV: begin
                    rem_q  <= rem_n;
                    quot_q <= quot_n;
                    cnt    <= cnt - 1'b1;
                    // Last iteration: apply signs to the final step's result directly.
                    if (cnt == CW'(1)) begin
                        state    <= DONE;
                        lo       <= neg_quot ? -quot_n : quot_n;
                        hi       <= neg_rem ? -rem_n : rem_n;
                        div_zero <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_zero;

    int total = 0;
    int bad   = 0;
    int cyc;
    int pulses;
    logic busy_ok;

    muldiv_unit #(.WIDTH(32), .MUL_LAT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo),
        .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1; op = o; a = x; b = y;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'b11; a = 32'hDEADBEEF; b = 32'h0;
    endtask

    // Called just after the accepting edge; returns the cycle number of done (0 = none).
    task automatic wait_done(output int c, output logic all_busy);
        c = 0;
        all_busy = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            @(negedge clk);
            if (!busy) all_busy = 1'b0;
            if (done) begin
                c = k;
                break;
            end
        end
    endtask

    task automatic count_done(input int n, output int p);
        p = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (done) p++;
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cancel = 1'b0; op = 2'b00; a = '0; b = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_hi", hi, 0);
        check("rst_lo", lo, 0);
        check("rst_dz", div_zero, 0);
        rst = 1'b0;

        // signed and unsigned multiply
        launch(2'b00, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc, busy_ok);
        check("mult_cycle", cyc, 2);
        check("mult_hi", hi, 32'hFFFFFFFF);
        check("mult_lo", lo, 32'hFFFFFFF1);
        check("mult_dz", div_zero, 0);
        @(negedge clk);
        check("mult_done_pulse", done, 0);
        check("mult_idle_busy", busy, 0);

        launch(2'b01, 32'hFFFFFFFD, 32'd5);
        wait_done(cyc, busy_ok);
        check("multu_cycle", cyc, 2);
        check("multu_hi", hi, 32'h4);
        check("multu_lo", lo, 32'hFFFFFFF1);

        // divide
        launch(2'b10, 32'hFFFFFFF9, 32'd2);
        wait_done(cyc, busy_ok);
        check("div_cycle", cyc, 33);
        check("div_busy", busy_ok, 1);
        check("div_lo", lo, 32'hFFFFFFFD);
        check("div_hi", hi, 32'hFFFFFFFF);

        launch(2'b11, 32'd7, 32'd2);
        wait_done(cyc, busy_ok);
        check("divu_lo", lo, 3);
        check("divu_hi", hi, 1);

        launch(2'b10, 32'h80000000, 32'hFFFFFFFF);
        wait_done(cyc, busy_ok);
        check("ovf_lo", lo, 32'h80000000);
        check("ovf_hi", hi, 0);
        check("ovf_dz", div_zero, 0);

        launch(2'b11, 32'h12345678, 32'h0);
        wait_done(cyc, busy_ok);
        check("dz_cycle", cyc, 1);
        check("dz_flag", div_zero, 1);
        check("dz_lo", lo, 32'hFFFFFFFF);
        check("dz_hi", hi, 32'h12345678);
        @(negedge clk);
        check("dz_held", div_zero, 1);

        // cancel mid-divide
        launch(2'b11, 32'd100, 32'd7);
        wait_done(cyc, busy_ok);
        check("d100_lo", lo, 14);
        check("d100_hi", hi, 2);
        check("d100_dz", div_zero, 0);
        launch(2'b10, 32'd1000, 32'd3);
        repeat (9) @(posedge clk);
        #1 cancel = 1'b1;
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel_busy", busy, 0);
        check("cancel_done", done, 0);
        check("cancel_hi", hi, 2);
        check("cancel_lo", lo, 14);
        count_done(40, pulses);
        check("cancel_no_done", pulses, 0);

        launch(2'b00, 32'd3, 32'd4);
        wait_done(cyc, busy_ok);
        check("m34_lo", lo, 12);
        check("m34_hi", hi, 0);

        // back-to-back start in the done cycle
        launch(2'b11, 32'd50, 32'd6);
        wait_done(cyc, busy_ok);
        check("b2b_div_lo", lo, 8);
        check("b2b_div_hi", hi, 2);
        start = 1'b1; op = 2'b01; a = 32'd6; b = 32'd7;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, busy_ok);
        check("b2b_mul_cycle", cyc, 2);
        check("b2b_mul_lo", lo, 42);

        // start during divide is ignored
        launch(2'b11, 32'd9, 32'd4);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(cyc, busy_ok);
        check("ign_cycle", cyc, 28);
        check("ign_lo", lo, 2);
        check("ign_hi", hi, 1);
        count_done(40, pulses);
        check("ign_no_extra", pulses, 0);

        // asynchronous reset mid-divide
        launch(2'b10, 32'd1000, 32'd7);
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_hi", hi, 0);
        check("arst_lo", lo, 0);
        check("arst_dz", div_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        launch(2'b00, 32'hFFFFFFFE, 32'd3);
        wait_done(cyc, busy_ok);
        check("post_cycle", cyc, 2);
        check("post_hi", hi, 32'hFFFFFFFF);
        check("post_lo", lo, 32'hFFFFFFFA);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
